id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 SHALL have parameter OPC_W, default 6, ALU opcode width.
REQ-003 SHALL have parameter REG_W, default 5, register-index width.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports id_valid/id_use_imm/id_is_load/id_reg_write  in  1 each  decoded instruction flags.
REQ-007 SHALL have ports id_opcode  in  OPC_W; id_rs1, id_rs2, id_rd  in  REG_W  decoded fields.
REQ-008 SHALL have ports id_rs1_data, id_rs2_data, id_imm  in  DATA_W  register-file read data and immediate.
REQ-009 SHALL have port flush_in  in  1  branch/jump taken in EX; kill the ID instruction.
REQ-010 SHALL have ports exmem_reg_write  in  1, exmem_rd  in  REG_W, exmem_result  in  DATA_W  EX/MEM forwarding source.
REQ-011 SHALL have ports memwb_reg_write  in  1, memwb_rd  in  REG_W, memwb_result  in  DATA_W  MEM/WB forwarding source.
REQ-012 SHALL have ports alu_a, alu_b  out  DATA_W; alu_opcode  out  OPC_W  ALU operands.
REQ-013 SHALL have ports ex_valid, ex_is_load, ex_reg_write  out  1; ex_rd  out  REG_W; ex_store_data  out  DATA_W  EX sideband.
REQ-014 SHALL have port stall_out  out  1  hold PC and IF/ID this cycle.

Function
REQ-015 SHALL register all id_* inputs on every rising clk edge unless bubble or flush applies.
REQ-016 SHALL define a bubble as valid=0, opcode=NOP (0), reg_write=0, is_load=0, rd=0, with all data fields zeroed.
REQ-017 SHALL assert stall_out combinationally when ex_valid & ex_is_load & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_use_imm)), and flush_in=0.
REQ-018 SHALL load a bubble on the edge where stall_out=1; the held ID instruction is captured on the following edge, one stall cycle per load-use.
REQ-019 SHALL load a bubble when flush_in=1; flush overrides stall, and stall_out SHALL be 0 in that cycle.
REQ-020 SHALL forward combinationally from registered rs1/rs2: use exmem_result if exmem_reg_write & exmem_rd==rs & rs!=0; else memwb_result if memwb_reg_write & memwb_rd==rs & rs!=0; else the registered data.
REQ-021 SHALL give EX/MEM priority over MEM/WB when both match.
REQ-022 SHALL never forward to index 0.
REQ-023 SHALL drive alu_a = forwarded rs1, and alu_b = registered imm if use_imm else forwarded rs2.
REQ-024 SHALL drive ex_store_data = forwarded rs2 regardless of use_imm.
REQ-025 SHALL drive alu_opcode, ex_rd, ex_valid, ex_is_load, ex_reg_write directly from register state, with zero combinational latency from the stage register.
REQ-026 SHALL give EX-stage latency of exactly one cycle from ID inputs to outputs when not stalled or flushed.

Reset
REQ-027 SHALL, while rst=1, asynchronously hold the bubble state, giving alu_a=0, alu_b=0, alu_opcode=0, ex_*=0 and stall_out=0.
REQ-028 SHALL discard any in-flight instruction or pending stall on reset assertion mid-operation; the first post-reset edge captures id_* normally.

Structure
REQ-029 SHALL take DATA_W/OPC_W/REG_W defaults and the NOP opcode value from the shared pipeline definitions header, which also serves the ALU and the other stage registers.
REQ-030 SHALL contain one sub-module fwd_mux, a 2-source priority forwarding selector, instantiated twice (rs1, rs2); hazard detection stays inline.

Verification
REQ-031 SHALL cover this scenario: no hazard, id_opcode=5, rs1_data=123, rs2_data=124 -> next cycle alu_a=123, alu_b=124, alu_opcode=5, ex_valid=1.
REQ-032 SHALL cover this scenario: EX holds rd=3; exmem_rd=3 with result 1223, memwb_rd=3 with result 7 -> alu_a=1223.
REQ-033 SHALL cover this scenario: EX holds load rd=4, ID rs2=4 with use_imm=0 -> stall_out=1 for one cycle, next cycle ex_valid=0/opcode=0, then the instruction enters with alu_b=memwb_result.
REQ-034 SHALL cover this scenario: load-use condition and flush_in=1 together -> stall_out=0, next cycle bubble.
REQ-035 SHALL cover this scenario: exmem_rd=0 with exmem_reg_write=1 and result 0xFFFFFFFF, rs1=0 -> alu_a=0.
REQ-036 SHALL cover this scenario: rst pulsed asynchronously mid-stall -> all outputs 0 immediately, stall_out=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: default widths, the NOP opcode and the forwarding-source encoding.
package id_ex_stage_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_OPC_W  = 6;
  localparam int unsigned PIPE_REG_W  = 5;

  localparam logic [PIPE_OPC_W-1:0] OPC_NOP = '0;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Two-source priority forwarding selector: EX/MEM beats MEM/WB, register x0 is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned REG_W  = PIPE_REG_W
) (
  input  logic [REG_W-1:0]  rs_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_we_i,
  input  logic [REG_W-1:0]  exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_res_i,
  input  logic              memwb_we_i,
  input  logic [REG_W-1:0]  memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_res_i,
  output logic [DATA_W-1:0] data_o
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (rs_i != '0) begin
      if (exmem_we_i && (exmem_rd_i == rs_i))      sel = FWD_EXMEM;
      else if (memwb_we_i && (memwb_rd_i == rs_i)) sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: data_o = exmem_res_i;
      FWD_MEMWB: data_o = memwb_res_i;
      default:   data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush-to-bubble and operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned OPC_W  = PIPE_OPC_W,
  parameter int unsigned REG_W  = PIPE_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_use_imm,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              flush_in,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic              ex_valid,
  output logic              ex_is_load,
  output logic              ex_reg_write,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_out
);

  localparam logic [OPC_W-1:0] NOP = OPC_W'(OPC_NOP);

  logic              valid_q, valid_d, use_imm_q, use_imm_d;
  logic              is_load_q, is_load_d, reg_write_q, reg_write_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic              load_use, bubble;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // Hazard is judged against the instruction currently in EX (the register state).
  always_comb begin
    load_use = valid_q && is_load_q && (rd_q != '0) && id_valid &&
               ((rd_q == id_rs1) || ((rd_q == id_rs2) && !id_use_imm));
    stall_out = load_use && !flush_in;
    bubble    = load_use || flush_in;
  end

  always_comb begin
    valid_d     = id_valid;
    use_imm_d   = id_use_imm;
    is_load_d   = id_is_load;
    reg_write_d = id_reg_write;
    opcode_d    = id_opcode;
    rs1_d       = id_rs1;
    rs2_d       = id_rs2;
    rd_d        = id_rd;
    rs1_data_d  = id_rs1_data;
    rs2_data_d  = id_rs2_data;
    imm_d       = id_imm;
    if (bubble) begin
      valid_d     = 1'b0;
      use_imm_d   = 1'b0;
      is_load_d   = 1'b0;
      reg_write_d = 1'b0;
      opcode_d    = NOP;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      use_imm_q   <= 1'b0;
      is_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
      opcode_q    <= NOP;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      use_imm_q   <= use_imm_d;
      is_load_q   <= is_load_d;
      reg_write_q <= reg_write_d;
      opcode_q    <= opcode_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs1 (
    .rs_i(rs1_q), .reg_data_i(rs1_data_q),
    .exmem_we_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_res_i(exmem_result),
    .memwb_we_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_res_i(memwb_result),
    .data_o(fwd_rs1)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs2 (
    .rs_i(rs2_q), .reg_data_i(rs2_data_q),
    .exmem_we_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_res_i(exmem_result),
    .memwb_we_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_res_i(memwb_result),
    .data_o(fwd_rs2)
  );

  assign alu_a         = fwd_rs1;
  assign alu_b         = use_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_opcode    = opcode_q;
  assign ex_valid      = valid_q;
  assign ex_is_load    = is_load_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, mid-stall reset sequence, randomized run against a model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_imm, id_is_load, id_reg_write;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        flush_in;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_opcode;
  logic        ex_valid, ex_is_load, ex_reg_write, stall_out;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .OPC_W(6), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .flush_in(flush_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .stall_out(stall_out)
  );

  typedef struct {
    logic v, ui, ld, rw;
    logic [5:0] opc;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic fl, xw;
    logic [4:0] xrd;
    logic [31:0] xres;
    logic mw;
    logic [4:0] mrd;
    logic [31:0] mres;
    logic e_stall, e_valid;
    logic [5:0] e_opc;
    logic [31:0] e_a, e_b;
    logic [4:0] e_rd;
  } vec_t;

  // Instruction held in EX, as the specification describes it.
  typedef struct {
    logic v, ui, ld, rw;
    logic [5:0] opc;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
  } instr_t;

  instr_t m;
  vec_t   tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] v, ui, ld, rw, opc, rs1, rs2, rd, d1, d2, imm, fl,
    input logic [31:0] xw, xrd, xres, mw, mrd, mres, es, ev, eopc, ea, eb, erd);
    vec_t t;
    t.v = v[0]; t.ui = ui[0]; t.ld = ld[0]; t.rw = rw[0]; t.opc = opc[5:0];
    t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.rd = rd[4:0];
    t.d1 = d1; t.d2 = d2; t.imm = imm; t.fl = fl[0];
    t.xw = xw[0]; t.xrd = xrd[4:0]; t.xres = xres;
    t.mw = mw[0]; t.mrd = mrd[4:0]; t.mres = mres;
    t.e_stall = es[0]; t.e_valid = ev[0]; t.e_opc = eopc[5:0];
    t.e_a = ea; t.e_b = eb; t.e_rd = erd[4:0];
    return t;
  endfunction

  task automatic drive_vec(input vec_t t);
    id_valid = t.v; id_use_imm = t.ui; id_is_load = t.ld; id_reg_write = t.rw;
    id_opcode = t.opc; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_rs1_data = t.d1; id_rs2_data = t.d2; id_imm = t.imm; flush_in = t.fl;
    exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
    memwb_reg_write = t.mw; memwb_rd = t.mrd; memwb_result = t.mres;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs == 5'd0) return d;
    if (exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd == rs) return memwb_result;
    return d;
  endfunction

  function automatic logic model_stall();
    if (flush_in || !id_valid || !(m.v && m.ld) || m.rd == 5'd0) return 1'b0;
    return (m.rd == id_rs1) || (m.rd == id_rs2 && !id_use_imm);
  endfunction

  task automatic model_edge(input logic stall_exp);
    if (flush_in || stall_exp) m = '{default: '0};
    else m = '{v: id_valid, ui: id_use_imm, ld: id_is_load, rw: id_reg_write, opc: id_opcode,
               rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm};
  endtask

  task automatic check_model(input string tag);
    logic [31:0] s;
    s = fwd(m.rs2, m.d2);
    chk({tag, ".alu_a"}, alu_a, fwd(m.rs1, m.d1));
    chk({tag, ".alu_b"}, alu_b, m.ui ? m.imm : s);
    chk({tag, ".store"}, ex_store_data, s);
    chk({tag, ".opc"}, 32'(alu_opcode), 32'(m.opc));
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".is_load"}, 32'(ex_is_load), 32'(m.ld));
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m.rw));
    chk({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".alu_a"}, alu_a, 32'd0);
    chk({tag, ".alu_b"}, alu_b, 32'd0);
    chk({tag, ".opc"}, 32'(alu_opcode), 32'd0);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".is_load"}, 32'(ex_is_load), 32'd0);
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'd0);
    chk({tag, ".rd"}, 32'(ex_rd), 32'd0);
    chk({tag, ".stall"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    vec_t z;
    logic es, prev_stall;
    z = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    drive_vec(z);
    rst = 1'b1;

    tbl[0] = mk(1,0,0,1,5, 1,2,7,  123,124,0, 0, 0,0,0, 0,0,0,        0,1,5,123,124,7);
    tbl[1] = mk(1,0,0,1,1, 3,0,3,  55,0,0,    0, 1,3,1223, 1,3,7,     0,1,1,1223,0,3);
    tbl[2] = mk(1,1,1,1,2, 1,0,4,  1000,0,8,  0, 0,0,0, 0,0,0,        0,1,2,1000,8,4);
    tbl[3] = mk(1,0,0,1,3, 5,4,6,  11,22,0,   0, 0,0,0, 1,4,'hABCD,   1,0,0,0,0,0);
    tbl[4] = mk(1,0,0,1,3, 5,4,6,  11,22,0,   0, 0,0,0, 1,4,'hABCD,   0,1,3,11,'hABCD,6);
    tbl[5] = mk(1,1,1,1,2, 1,0,9,  5,0,4,     0, 0,0,0, 0,0,0,        0,1,2,5,4,9);
    tbl[6] = mk(1,0,0,1,7, 9,0,10, 1,0,0,     1, 0,0,0, 0,0,0,        0,0,0,0,0,0);
    tbl[7] = mk(1,0,0,1,4, 0,1,2,  0,77,0,    0, 1,0,'hFFFFFFFF, 0,0,0, 0,1,4,0,77,2);
    tbl[8] = mk(1,1,1,1,2, 1,0,12, 3,0,1,     0, 0,0,0, 0,0,0,        0,1,2,3,1,12);
    tbl[9] = mk(1,1,0,1,6, 13,12,1, 40,9,2,   0, 0,0,0, 0,0,0,        0,1,6,40,2,1);

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive_vec(tbl[i]);
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(stall_out), 32'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.opc", i), 32'(alu_opcode), 32'(tbl[i].e_opc));
      chk($sformatf("vec%0d.alu_a", i), alu_a, tbl[i].e_a);
      chk($sformatf("vec%0d.alu_b", i), alu_b, tbl[i].e_b);
      chk($sformatf("vec%0d.rd", i), 32'(ex_rd), 32'(tbl[i].e_rd));
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive_vec(mk(1,1,1,1,2, 0,0,4, 0,0,16, 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive_vec(mk(1,0,0,1,3, 4,0,5, 'h55,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    #1;
    chk("rstseq.stall_pre", 32'(stall_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_zero("rstseq.async");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstseq.valid", 32'(ex_valid), 32'd1);
    chk("rstseq.opc", 32'(alu_opcode), 32'd3);
    chk("rstseq.alu_a", alu_a, 32'h55);
    chk("rstseq.rd", 32'(ex_rd), 32'd5);

    // Randomized run against the EX-stage model.
    @(negedge clk);
    rst = 1'b1;
    m = '{default: '0};
    #1 rst = 1'b0;
    prev_stall = 1'b0;
    for (int unsigned c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!prev_stall) begin
        id_valid     = ($urandom_range(0, 9) != 0);
        id_use_imm   = 1'($urandom_range(0, 1));
        id_is_load   = ($urandom_range(0, 2) == 0);
        id_reg_write = 1'($urandom_range(0, 1));
        id_opcode    = 6'($urandom);
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom_range(0, 7));
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
      end
      flush_in        = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_result    = $urandom;
      #1;
      es = model_stall();
      chk("rand.stall", 32'(stall_out), 32'(es));
      @(posedge clk);
      model_edge(es);
      prev_stall = es;
      #1;
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
